// File: rtl/nor_32bit.sv
// nor_32bit: bitwise NOR unit for the ALU logic-operation path.
//   Combinational result outC = ~(inA | inB), built one 2-input NOR per bit,
//   with combinational zero / all_ones status flags derived from outC.
//   A registered copy (out_q) with a one-cycle valid pulse (out_valid) serves
//   pipelined consumers; clk / rst_n touch only that registered path.
// Ports:
//   clk       rising-edge clock for the registered path
//   rst_n     asynchronous active-low reset (registered path only)
//   inA, inB  operands, WIDTH bits
//   in_valid  capture strobe for the registered path
//   outC      combinational NOR result
//   zero      combinational: outC is all zeros
//   all_ones  combinational: outC is all ones
//   out_q     registered NOR result, held when in_valid is low
//   out_valid one-cycle pulse: out_q was captured on the previous edge
module nor_32bit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] inA,
   input  logic [WIDTH-1:0] inB,
   input  logic             in_valid,
   output logic [WIDTH-1:0] outC,
   output logic             zero,
   output logic             all_ones,
   output logic [WIDTH-1:0] out_q,
   output logic             out_valid
);

   // One independent NOR gate per bit; no cross-bit logic, so X/Z on an
   // input bit can only reach the matching output bit and the flags.
   for (genvar i = 0; i < int'(WIDTH); i++) begin : g_nor
      assign outC[i] = ~(inA[i] | inB[i]);
   end

   // Status flags follow outC with no latency.
   assign zero     = ~|outC;
   assign all_ones = &outC;

   // Registered copy: capture on in_valid, otherwise hold data and drop valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q     <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            out_q <= outC;
         end
      end
   end

endmodule

// File: tb/tb_nor_32bit.sv
// tb_nor_32bit: self-checking bench for nor_32bit.
//   Directed corner vectors, reset/valid sequencing, asynchronous reset, then
//   randomized operands checked against a per-bit truth-rule reference model
//   and a transaction-level model of the registered path.
module tb_nor_32bit;

   localparam int unsigned WIDTH = 32;

   logic             clk;
   logic             rst_n;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_valid;
   logic [WIDTH-1:0] out_c;
   logic             zero;
   logic             all_ones;
   logic [WIDTH-1:0] out_q;
   logic             out_valid;

   int tests_run = 0;
   int tests_failed = 0;

   // Reference state of the registered path.
   logic [WIDTH-1:0] exp_q;
   logic             exp_v;

   nor_32bit #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .inA       (in_a),
      .inB       (in_b),
      .in_valid  (in_valid),
      .outC      (out_c),
      .zero      (zero),
      .all_ones  (all_ones),
      .out_q     (out_q),
      .out_valid (out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [WIDTH-1:0] got,
                        input logic [WIDTH-1:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Truth rule: an output bit is 1 exactly when neither operand bit is 1.
   function automatic logic [WIDTH-1:0] ref_nor(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
      logic [WIDTH-1:0] r;
      for (int i = 0; i < int'(WIDTH); i++) begin
         r[i] = ((int'(a[i]) + int'(b[i])) == 0);
      end
      return r;
   endfunction

   function automatic int count_ones(input logic [WIDTH-1:0] v);
      int n = 0;
      for (int i = 0; i < int'(WIDTH); i++) n += int'(v[i]);
      return n;
   endfunction

   // Apply operands, let them settle, check outC and both flags.
   task automatic comb_check(input string tag, input logic [WIDTH-1:0] a,
                             input logic [WIDTH-1:0] b);
      logic [WIDTH-1:0] e;
      int               n;
      in_a = a;
      in_b = b;
      #5;
      e = ref_nor(a, b);
      n = count_ones(e);
      check({tag, ".outC"}, out_c, e);
      check({tag, ".zero"}, WIDTH'(zero), WIDTH'(n == 0));
      check({tag, ".all_ones"}, WIDTH'(all_ones), WIDTH'(n == int'(WIDTH)));
   endtask

   initial begin
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] e;
      int               mode;
      int               n;

      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_a     = '0;
      in_b     = '0;
      exp_q    = '0;
      exp_v    = 1'b0;
      #1;
      check("reset.out_q", out_q, '0);
      check("reset.out_valid", WIDTH'(out_valid), '0);

      // Directed corner vectors (reset held; outC must not care).
      comb_check("a0_b1", 32'h0000_0000, 32'hFFFF_FFFF);
      comb_check("a1_b0", 32'hFFFF_FFFF, 32'h0000_0000);
      comb_check("a0_b0", 32'h0000_0000, 32'h0000_0000);
      comb_check("a1_b1", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      comb_check("a5_0f", 32'hA5A5_A5A5, 32'h0F0F_0F0F);
      check("a5_0f.const", out_c, 32'h5050_5050);

      // Clock with in_valid high while reset is held.
      in_valid = 1'b1;
      in_a     = 32'h1234_5678;
      in_b     = 32'h0000_FF00;
      repeat (3) @(posedge clk);
      #1;
      check("inrst.out_q", out_q, '0);
      check("inrst.out_valid", WIDTH'(out_valid), '0);
      check("inrst.outC", out_c, ref_nor(32'h1234_5678, 32'h0000_FF00));

      // Release reset, one capture of 0 NOR 0.
      @(negedge clk);
      rst_n    = 1'b1;
      in_valid = 1'b1;
      in_a     = '0;
      in_b     = '0;
      @(posedge clk);
      #1;
      check("cap.out_q", out_q, 32'hFFFF_FFFF);
      check("cap.out_valid", WIDTH'(out_valid), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      in_a     = 32'hFFFF_FFFF;
      @(posedge clk);
      #1;
      check("hold.out_q", out_q, 32'hFFFF_FFFF);
      check("hold.out_valid", WIDTH'(out_valid), '0);

      // Asynchronous reset between edges while out_valid is high.
      @(negedge clk);
      in_valid = 1'b1;
      in_a     = 32'h0F0F_0000;
      in_b     = 32'h00F0_0000;
      @(posedge clk);
      #1;
      check("pre_arst.out_valid", WIDTH'(out_valid), 32'd1);
      check("pre_arst.out_q", out_q, ref_nor(32'h0F0F_0000, 32'h00F0_0000));
      #1;
      rst_n = 1'b0;
      #1;
      check("arst.out_q", out_q, '0);
      check("arst.out_valid", WIDTH'(out_valid), '0);
      @(negedge clk);
      rst_n    = 1'b1;
      in_valid = 1'b0;
      exp_q    = '0;
      exp_v    = 1'b0;

      // Randomized operands against the reference model.
      for (int t = 0; t < 300; t++) begin
         @(negedge clk);
         mode = int'($urandom_range(0, 4));
         a    = $urandom;
         b    = $urandom;
         case (mode)
            1: b = ~a | (a & $urandom);
            2: begin a = '0; b = '0; end
            3: b = a & $urandom;
            default: ;
         endcase
         in_a     = a;
         in_b     = b;
         in_valid = ($urandom_range(0, 3) != 0);
         #1;
         e = ref_nor(a, b);
         n = count_ones(e);
         check("rnd.outC", out_c, e);
         check("rnd.zero", WIDTH'(zero), WIDTH'(n == 0));
         check("rnd.all_ones", WIDTH'(all_ones), WIDTH'(n == int'(WIDTH)));
         // Operand symmetry: swapped operands give the same result.
         in_a = b;
         in_b = a;
         #1;
         check("rnd.swap", out_c, e);
         if (in_valid) begin
            exp_q = e;
            exp_v = 1'b1;
         end else begin
            exp_v = 1'b0;
         end
         @(posedge clk);
         #1;
         check("rnd.out_q", out_q, exp_q);
         check("rnd.out_valid", WIDTH'(out_valid), WIDTH'(exp_v));
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/nor_32bit.md
Name: nor_32bit

Overview:
- Bitwise 32-bit NOR unit for the ALU logic-operation path of the single-cycle processor.
- Combinational result port outC = ~(inA | inB), built as per-bit 2-input NOR gates with no intermediate logic levels.
- Registered result copy with valid flag, plus zero and all-ones status flags, for the pipelined/status consumers.
- Clock and reset apply only to the registered path; outC never depends on them.

Parameters:
- WIDTH, 32, operand/result width in bits; all vectors are [WIDTH-1:0]; only 32 is required to be verified.

Ports:
- clk  input  1  rising-edge clock for registered path
- rst_n  input  1  asynchronous active-low reset
- outC  output  WIDTH  combinational result ~(inA | inB)
- inA  input  WIDTH  operand A
- inB  input  WIDTH  operand B
- in_valid  input  1  capture strobe for registered path
- out_q  output  WIDTH  registered result
- out_valid  output  1  out_q holds a result captured on the previous edge
- zero  output  1  combinational: outC == 0
- all_ones  output  1  combinational: outC == all ones

Behaviour:
- One clock (clk), asynchronous active-low reset (rst_n).
- outC[i] = NOT(inA[i] OR inB[i]) for every bit i independently; no carries, no cross-bit interaction.
- outC is purely combinational, zero cycles latency, and must settle within 5 time units of an input change.
- outC is unaffected by clk, rst_n and in_valid, including while reset is asserted.
- Operand A and operand B are symmetric: swapping inA and inB gives an identical outC.
- zero = 1 iff every outC bit is 0, i.e. at least one operand has a 1 in every bit position.
- all_ones = 1 iff both operands are all zeros.
- zero and all_ones are combinational, follow outC with no latency, and are never both 1 when WIDTH >= 1.
- Reset: rst_n low asynchronously forces out_q = 0 and out_valid = 0; both hold while rst_n is low.
- Registered path, rising clk with rst_n high:
  - if in_valid = 1: out_q <= ~(inA | inB) and out_valid <= 1;
  - if in_valid = 0: out_q holds its value and out_valid <= 0.
- out_valid is a one-cycle pulse per captured operand pair; back-to-back in_valid gives back-to-back results, one per cycle, with no bubbles.
- Reset asserted mid-operation discards any pending result. The first capture after rst_n deasserts occurs on the first rising edge with in_valid = 1.
- X/Z on an input bit propagates only to the corresponding output bit and the flags; no other bit is affected.

Test Plan:
- inA=0x00000000, inB=0xFFFFFFFF, wait 5 -> outC=0x00000000, zero=1, all_ones=0.
- inA=0xFFFFFFFF, inB=0x00000000, wait 5 -> outC=0x00000000, zero=1, all_ones=0 (operand symmetry).
- inA=0x00000000, inB=0x00000000, wait 5 -> outC=0xFFFFFFFF, zero=0, all_ones=1.
- inA=0xFFFFFFFF, inB=0xFFFFFFFF, wait 5 -> outC=0x00000000, zero=1; then inA=0xA5A5A5A5, inB=0x0F0F0F0F -> outC=0x50505050, zero=0, all_ones=0.
- Hold rst_n=0 and toggle clk with in_valid=1 -> out_q=0, out_valid=0, outC still tracks inputs. Release rst_n, apply inA=inB=0 with in_valid=1 for one edge -> out_q=0xFFFFFFFF and out_valid=1 for exactly one cycle, then out_valid=0 with out_q held.
- Assert rst_n=0 asynchronously between edges while out_valid=1 -> out_q and out_valid clear immediately, before the next clk edge.
